// File: rtl/mcp_counter_bank.sv
// Multi-channel up/down counter bank that advances only on a shared strobe
// issued once every DIV clocks. Loads arriving between strobes are deferred.
module mcp_counter_bank #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 32,
    parameter int DIV    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         en,
    input  logic [NUM_CH-1:0]         dir,
    input  logic [NUM_CH-1:0]         sat,
    input  logic [NUM_CH-1:0]         load,
    input  logic [NUM_CH*WIDTH-1:0]   load_val,
    output logic [NUM_CH*WIDTH-1:0]   q,
    output logic [NUM_CH-1:0]         tc,
    output logic                      strobe
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             strobe_q, strobe_d;

    // strobe_q is registered from the next phase, so it is high exactly
    // while div_cnt_q sits at DIV-1 (and on every cycle when DIV=1).
    always_comb begin
        div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
        strobe_d  = (div_cnt_d == DIV_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q <= '0;
            strobe_q  <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            strobe_q  <= strobe_d;
        end
    end

    assign strobe = strobe_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [WIDTH-1:0] cnt_q, cnt_d;
            logic [WIDTH-1:0] shadow_q, shadow_d;
            logic [WIDTH-1:0] ld_val;
            logic             pend_q, pend_d;
            logic             tc_q, tc_d;
            logic             at_limit;

            always_comb begin
                ld_val   = load_val[gi*WIDTH +: WIDTH];
                at_limit = dir[gi] ? (cnt_q == '1) : (cnt_q == '0);
                cnt_d    = cnt_q;
                shadow_d = shadow_q;
                pend_d   = pend_q;
                tc_d     = 1'b0;
                if (strobe_q) begin
                    if (load[gi]) begin
                        cnt_d  = ld_val;
                        pend_d = 1'b0;
                    end else if (pend_q) begin
                        cnt_d  = shadow_q;
                        pend_d = 1'b0;
                    end else if (en[gi]) begin
                        // A step at a limit either wraps or is blocked; both flag tc.
                        tc_d = at_limit;
                        if (!(at_limit && sat[gi])) begin
                            cnt_d = dir[gi] ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
                        end
                    end
                end else if (load[gi]) begin
                    shadow_d = ld_val;
                    pend_d   = 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q    <= '0;
                    shadow_q <= '0;
                    pend_q   <= 1'b0;
                    tc_q     <= 1'b0;
                end else begin
                    cnt_q    <= cnt_d;
                    shadow_q <= shadow_d;
                    pend_q   <= pend_d;
                    tc_q     <= tc_d;
                end
            end

            assign q[gi*WIDTH +: WIDTH] = cnt_q;
            assign tc[gi]               = tc_q;
        end
    endgenerate

endmodule

// File: doc/mcp_counter_bank.md
Name: mcp_counter_bank

Overview:
- Multi-channel counter bank whose count registers advance only on a shared strobe issued once every DIV clocks.
- Every register-to-register path through the counters is therefore a DIV-cycle multicycle path. This block is the STA vehicle for constraining multicycle paths set by DIV.
- Each channel has enable, up/down direction, wrap or saturate mode, a strobe-aligned deferred load, and a terminal-count pulse.

Parameters:
- NUM_CH, 4, number of independent counter channels (1..16).
- WIDTH, 32, counter width per channel in bits (2..64).
- DIV, 2, strobe period in clocks; also the multicycle factor (1..256). DIV=1 gives a strobe on every cycle.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  NUM_CH  per-channel count enable, sampled on strobe cycles only.
- dir  in  NUM_CH  per-channel direction; 1 = up, 0 = down.
- sat  in  NUM_CH  per-channel mode; 1 = saturate at the limits, 0 = wrap modulo 2^WIDTH.
- load  in  NUM_CH  per-channel load request, one-cycle pulse.
- load_val  in  NUM_CH*WIDTH  load values; channel i occupies bits [i*WIDTH +: WIDTH].
- q  out  NUM_CH*WIDTH  counter values, same packing as load_val.
- tc  out  NUM_CH  per-channel terminal-count pulse.
- strobe  out  1  registered strobe, for bench and constraint cross-check.

Behaviour:
- Clocking and reset
  - Single clock domain.
  - Reset is synchronous and active-high.
  - Reset overrides every other input.
- Strobe generator
  - div_cnt is a ceil(log2(DIV))-bit counter (at least 1 bit). It resets to 0 and counts 0..DIV-1, then wraps to 0.
  - strobe is a register. It resets to 0.
  - strobe is 1 during the cycle in which div_cnt == DIV-1.
  - After reset deasserts, the first strobe appears in the DIV-th cycle, then every DIV cycles.
  - DIV=2 produces the pattern 0,1,0,1...
  - DIV=1: strobe resets to 0, then stays at 1 on every cycle.
- Update rule
  - q[i] changes only on the clock edge that ends a cycle with strobe=1.
- Channel priority on a strobe edge, highest first
  1. Reset.
  2. Live load: load[i]=1 in the same cycle. q <= load_val[i] immediately; pending is cleared.
  3. Pending load: q <= shadow[i]; pending is cleared.
  4. Count: en[i]=1; step by +1 or -1 according to dir.
  5. Hold.
- Deferred load
  - A load pulse in a non-strobe cycle captures load_val[i] into shadow[i] and sets pend[i].
  - A later load before the strobe overwrites shadow (last write wins).
  - The counter keeps its value until the strobe, even if en=1.
  - Load ignores en.
- Arithmetic
  - Unsigned, WIDTH bits.
  - Wrap mode: max+1 -> 0 and 0-1 -> max.
  - Saturate mode: an up-step at max and a down-step at 0 leave q unchanged.
- tc[i]
  - Registered; resets to 0.
  - High for exactly one clock, in the cycle after a strobe edge on which a count step wrapped (sat=0) or was blocked at a limit (sat=1).
  - A load never generates tc.
  - tc is 0 on all other cycles.
- Reset values
  - q = 0, tc = 0, strobe = 0, pend = 0, shadow = 0, div_cnt = 0.
- Reset mid-operation
  - Pending loads are discarded.
  - The strobe phase restarts from div_cnt=0.
- Input sampling
  - en, dir and sat are sampled only in strobe cycles. Changes between strobes have no effect.
- Timing
  - Outputs are driven directly from registers; there are no combinational input-to-output paths.
  - Paths from q through the +/-1 logic back to q may be constrained as a DIV-cycle multicycle path (setup DIV, hold DIV-1).
  - The load_val to shadow path and the live-load path are single-cycle paths.

Test Plan:
- Strobe cadence. DIV=4, reset for 3 cycles, then release → strobe=1 on cycles 4, 8, 12 after release. With en=1, dir=1 on channel 0, q0 reads 1 after cycle 4 and 2 after cycle 8.
- Up wrap. DIV=2, WIDTH=8, sat=0: load 0xFE, then count up → q goes 0xFE, 0xFF, 0x00. tc pulses once, in the cycle after the 0xFF→0x00 edge.
- Saturate limits. sat=1, dir=0, load 0x01: two strobes → q=0x00 and stays 0x00. tc pulses once on the blocked step. Then switch to dir=1 with q at 0xFF: q holds 0xFF and tc pulses.
- Deferred load. DIV=8, en=1: pulse load=0x55 at div_cnt=2, then load=0xAA at div_cnt=5 → q unchanged until the strobe, then q=0xAA with no increment. At the next strobe q=0xAB. No tc.
- Live load on strobe with a pending load. A load is pending with shadow=0x10, and load_val=0x20 is asserted in a strobe cycle → q=0x20 and pend is cleared.
- Reset mid-operation and channel independence. NUM_CH=4 with mixed en/dir/sat, a pending load and div_cnt=3: assert reset for one cycle → q=0, tc=0, pend discarded, strobe phase restarts. Meanwhile a channel with en=0 never changes and never pulses tc.
